// File: rtl/trace_retire_queue_pkg.sv
// Shared types for the retirement tracer: record layout, instruction classes,
// RV32I/RV32M wildcard masks and the classifier built from them.
package trace_retire_queue_pkg;

    localparam int unsigned TRC_CYC_W = 32;

    typedef enum logic [3:0] {
        CLS_UNKNOWN = 4'd0,
        CLS_UPPER   = 4'd1,
        CLS_JUMP    = 4'd2,
        CLS_BRANCH  = 4'd3,
        CLS_LOAD    = 4'd4,
        CLS_STORE   = 4'd5,
        CLS_MULDIV  = 4'd6,
        CLS_ALU     = 4'd7,
        CLS_SYSTEM  = 4'd8,
        CLS_FENCE   = 4'd9
    } trace_cls_e;

    typedef struct packed {
        logic [TRC_CYC_W-1:0] cyc;
        logic [31:0]          pc;
        logic [31:0]          insn;
        logic [4:0]           rd;
        logic [31:0]          rd_wdata;
        trace_cls_e           cls;
    } trace_rec_t;

    localparam logic [31:0] INSN_LUI    = 32'b?????_?????_?????_?????_?????_0110111;
    localparam logic [31:0] INSN_AUIPC  = 32'b?????_?????_?????_?????_?????_0010111;
    localparam logic [31:0] INSN_JAL    = 32'b?????_?????_?????_?????_?????_1101111;
    localparam logic [31:0] INSN_JALR   = 32'b????????????_?????_000_?????_1100111;
    localparam logic [31:0] INSN_BEQ    = 32'b???????_?????_?????_000_?????_1100011;
    localparam logic [31:0] INSN_BNE    = 32'b???????_?????_?????_001_?????_1100011;
    localparam logic [31:0] INSN_BLT    = 32'b???????_?????_?????_100_?????_1100011;
    localparam logic [31:0] INSN_BGE    = 32'b???????_?????_?????_101_?????_1100011;
    localparam logic [31:0] INSN_BLTU   = 32'b???????_?????_?????_110_?????_1100011;
    localparam logic [31:0] INSN_BGEU   = 32'b???????_?????_?????_111_?????_1100011;
    localparam logic [31:0] INSN_LOAD   = 32'b?????_?????_?????_?????_?????_0000011;
    localparam logic [31:0] INSN_STORE  = 32'b?????_?????_?????_?????_?????_0100011;
    localparam logic [31:0] INSN_MULDIV = 32'b0000001_?????_?????_???_?????_0110011;
    localparam logic [31:0] INSN_OP     = 32'b?????_?????_?????_?????_?????_0110011;
    localparam logic [31:0] INSN_OP_IMM = 32'b?????_?????_?????_?????_?????_0010011;
    localparam logic [31:0] INSN_SYSTEM = 32'b?????_?????_?????_?????_?????_1110011;
    localparam logic [31:0] INSN_FENCE  = 32'b?????_?????_?????_?????_?????_0001111;

    // Priority order matters: RV32M shares the OP opcode and must win over ALU.
    function automatic trace_cls_e classify(input logic [31:0] insn);
        trace_cls_e cls;
        if (insn ==? INSN_LUI || insn ==? INSN_AUIPC)                        cls = CLS_UPPER;
        else if (insn ==? INSN_JAL || insn ==? INSN_JALR)                    cls = CLS_JUMP;
        else if (insn ==? INSN_BEQ || insn ==? INSN_BNE || insn ==? INSN_BLT ||
                 insn ==? INSN_BGE || insn ==? INSN_BLTU || insn ==? INSN_BGEU) cls = CLS_BRANCH;
        else if (insn ==? INSN_LOAD)                                         cls = CLS_LOAD;
        else if (insn ==? INSN_STORE)                                        cls = CLS_STORE;
        else if (insn ==? INSN_MULDIV)                                       cls = CLS_MULDIV;
        else if (insn ==? INSN_OP || insn ==? INSN_OP_IMM)                   cls = CLS_ALU;
        else if (insn ==? INSN_SYSTEM)                                       cls = CLS_SYSTEM;
        else if (insn ==? INSN_FENCE)                                        cls = CLS_FENCE;
        else                                                                 cls = CLS_UNKNOWN;
        return cls;
    endfunction

endpackage

// File: rtl/trace_retire_queue_fifo.sv
// Synchronous FIFO of trace records; extra pointer MSB separates full from empty.
module trace_fifo
    import trace_retire_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        wr_en_i,
    input  trace_rec_t  wr_data_i,
    input  logic        rd_en_i,
    output trace_rec_t  rd_data_o,
    output logic [AW:0] count_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    trace_rec_t  mem_q [DEPTH];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_en_i) wptr_d = wptr_q + PTR_ONE;
            if (rd_en_i) rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i && !clr_i) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rptr_q[AW-1:0]];
    assign count_o   = wptr_q - rptr_q;
    assign empty_o   = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/trace_retire_queue.sv
// Retired-instruction trace queue: classify, cycle-stamp, buffer and drain to the sink.
// Define TRACE_RETIRE_STALL_EN to backpressure the pipeline instead of dropping records.
module trace_retire_queue
    import trace_retire_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CYC_W = TRC_CYC_W
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ret_valid_i,
    input  logic [31:0] ret_pc_i,
    input  logic [31:0] ret_insn_i,
    input  logic [4:0]  ret_rd_i,
    input  logic [31:0] ret_rd_wdata_i,
    input  logic        flush_i,
    output logic        trc_valid_o,
    input  logic        trc_ready_i,
    output trace_rec_t  trc_rec_o,
    output logic        stall_o,
    output logic [15:0] ovf_cnt_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_FLUSH} state_e;

    state_e           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [AW:0]      count, count_nxt;
    logic             fifo_full, fifo_empty;
    logic             rd_en, wr_req, wr_en;
    trace_rec_t       cap_rec, head_rec;
    trace_cls_e       cap_cls;

    assign rd_en  = trc_valid_o && trc_ready_i;
    assign wr_req = ret_valid_i && !flush_i;
    // A read in the same cycle frees the head slot, so a full FIFO still takes the write.
    assign wr_en  = wr_req && (!fifo_full || rd_en);

    assign count_nxt = count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};

    assign cap_cls          = classify(ret_insn_i);
    assign cap_rec.cyc      = TRC_CYC_W'(cyc_q);
    assign cap_rec.pc       = ret_pc_i;
    assign cap_rec.insn     = ret_insn_i;
    assign cap_rec.rd       = ret_rd_i;
    assign cap_rec.rd_wdata = (ret_rd_i == 5'd0 || cap_cls == CLS_BRANCH || cap_cls == CLS_STORE)
                              ? 32'd0 : ret_rd_wdata_i;
    assign cap_rec.cls      = cap_cls;

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (flush_i),
        .wr_en_i   (wr_en),
        .wr_data_i (cap_rec),
        .rd_en_i   (rd_en),
        .rd_data_o (head_rec),
        .count_o   (count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q + CYC_W'(1);
        unique case (state_q)
            ST_IDLE:  if (count_nxt != '0) state_d = ST_SEND;
            ST_SEND:  if (count_nxt == '0) state_d = ST_IDLE;
            ST_FLUSH: state_d = (count_nxt != '0) ? ST_SEND : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_FLUSH;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
        end
    end

    assign trc_valid_o = (state_q == ST_SEND);
    assign trc_rec_o   = trc_valid_o ? head_rec : '0;
    assign full_o      = fifo_full;
    assign empty_o     = fifo_empty;

`ifdef TRACE_RETIRE_STALL_EN
    assign stall_o   = fifo_full && !rd_en;
    assign ovf_cnt_o = 16'd0;
`else
    logic [15:0] ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (wr_req && fifo_full && !rd_en && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ovf_q <= '0;
        else         ovf_q <= ovf_d;
    end

    assign stall_o   = 1'b0;
    assign ovf_cnt_o = ovf_q;
`endif

endmodule
